// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- control wrapper around a UART receive core.
//
// Generates the oversample tick for the receiver, sequences the receiver
// enable through IDLE / ARM / RUN / RECOVER, captures received bytes into a
// small show-ahead FIFO and keeps sticky overrun / framing-error statistics.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst_n      synchronous active-low reset
//   cfg_en     controller enable (low forces IDLE on the next edge)
//   cfg_div    clk cycles per oversample tick (0 or 1 -> every cycle)
//   rx_tick    one-clk tick pulse to the receiver
//   rx_en      receiver enable (high only in RUN)
//   rx_data    receiver byte
//   rx_done    receiver byte-complete level (rising edge pushes a byte)
//   rx_err     receiver framing-error level (rising edge counts an error)
//   rd_en      host pop request
//   rd_data    FIFO head, 0 when empty
//   rd_valid   FIFO not empty
//   level      FIFO occupancy, 0..FIFO_DEPTH
//   overrun    sticky flag: a byte was dropped on a full FIFO
//   err_count  saturating framing-error count
//   stat_clr   clears overrun and err_count (same-cycle events win)
//   active     high only in RUN
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int HOLDOFF    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_en,
  input  logic [15:0]                   cfg_div,
  output logic                          rx_tick,
  output logic                          rx_en,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_done,
  input  logic                          rx_err,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overrun,
  output logic [7:0]                    err_count,
  input  logic                          stat_clr,
  output logic                          active
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2(HOLDOFF + 1);
  localparam logic [AW:0]   DEPTH_L = (AW + 1)'(FIFO_DEPTH);
  localparam logic [HW-1:0] HOLD_L  = HW'(HOLDOFF);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_RUN     = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t          state_r;
  logic [15:0]     cnt_r;
  logic [HW-1:0]   hold_r;
  logic            done_q_r;
  logic            err_q_r;
  logic [7:0]      mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     level_r;
  logic            overrun_r;
  logic [7:0]      err_count_r;

  logic            tick_s;
  logic            done_rise_s;
  logic            err_rise_s;
  logic            push_req_s;
  logic            err_evt_s;
  logic            pop_s;
  logic            full_s;
  logic            push_ok_s;
  logic            ovf_s;

  // Tick decode, edge detection and FIFO push/pop qualification.
  always_comb begin
    tick_s      = 1'b0;
    if (state_r != S_IDLE) begin
      // 17-bit compare so cfg_div = 0xFFFF cannot wrap the count
      tick_s = (({1'b0, cnt_r} + 17'd1) >= {1'b0, cfg_div});
    end else begin
      tick_s = 1'b0;
    end
    done_rise_s = rx_done & ~done_q_r;
    err_rise_s  = rx_err & ~err_q_r;
    // a disable takes precedence: no byte or error is taken on that cycle;
    // an error edge masks a coincident byte edge
    err_evt_s   = cfg_en & (state_r == S_RUN) & err_rise_s;
    push_req_s  = cfg_en & (state_r == S_RUN) & done_rise_s & ~err_rise_s;
    pop_s       = rd_en & (level_r != '0);
    full_s      = (level_r == DEPTH_L);
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    push_ok_s   = push_req_s & (~full_s | pop_s);
    ovf_s       = push_req_s & full_s & ~pop_s;
  end

  // Control state, tick counter, FIFO pointers and statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      cnt_r       <= 16'd0;
      hold_r      <= '0;
      done_q_r    <= 1'b0;
      err_q_r     <= 1'b0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      level_r     <= '0;
      overrun_r   <= 1'b0;
      err_count_r <= 8'd0;
    end else begin
      done_q_r <= rx_done;
      err_q_r  <= rx_err;

      if ((state_r == S_IDLE) || tick_s) begin
        cnt_r <= 16'd0;
      end else begin
        cnt_r <= cnt_r + 16'd1;
      end

      if (!cfg_en) begin
        state_r <= S_IDLE;
      end else begin
        case (state_r)
          S_IDLE: begin
            state_r <= S_ARM;
          end
          S_ARM: begin
            // receiver always sees at least one tick while disabled
            if (tick_s) begin
              state_r <= S_RUN;
            end
          end
          S_RUN: begin
            if (err_rise_s) begin
              hold_r  <= HOLD_L;
              state_r <= S_RECOVER;
            end
          end
          S_RECOVER: begin
            if (tick_s) begin
              if (hold_r <= HW'(1)) begin
                hold_r  <= '0;
                state_r <= S_RUN;
              end else begin
                hold_r <= hold_r - HW'(1);
              end
            end
          end
          default: begin
            state_r <= S_IDLE;
          end
        endcase
      end

      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   level_r <= level_r + (AW + 1)'(1);
        2'b01:   level_r <= level_r - (AW + 1)'(1);
        default: level_r <= level_r;
      endcase

      // new events win over a same-cycle clear
      if (ovf_s) begin
        overrun_r <= 1'b1;
      end else if (stat_clr) begin
        overrun_r <= 1'b0;
      end

      if (err_evt_s) begin
        if (stat_clr) begin
          err_count_r <= 8'd1;
        end else if (err_count_r != 8'hFF) begin
          err_count_r <= err_count_r + 8'd1;
        end
      end else if (stat_clr) begin
        err_count_r <= 8'd0;
      end
    end
  end

  // FIFO storage; contents need no reset since reads are gated by level.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= rx_data;
    end
  end

  assign rx_tick   = tick_s;
  assign rx_en     = (state_r == S_RUN);
  assign active    = (state_r == S_RUN);
  assign rd_valid  = (level_r != '0);
  assign rd_data   = (level_r != '0) ? mem_r[rd_ptr_r] : 8'd0;
  assign level     = level_r;
  assign overrun   = overrun_r;
  assign err_count = err_count_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus randomized
// traffic, every cycle compared against a queue-based behavioural model.
module tb_uart_rx_ctrl;

  localparam int FIFO_DEPTH = 4;
  localparam int HOLDOFF    = 16;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;

  localparam int M_IDLE    = 0;
  localparam int M_ARM     = 1;
  localparam int M_RUN     = 2;
  localparam int M_RECOVER = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_en;
  logic [15:0]   cfg_div;
  logic          rx_tick;
  logic          rx_en;
  logic [7:0]    rx_data;
  logic          rx_done;
  logic          rx_err;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [LW-1:0] level;
  logic          overrun;
  logic [7:0]    err_count;
  logic          stat_clr;
  logic          active;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int         m_mode;
  int         m_cnt;
  int         m_hold;
  int         m_errs;
  bit         m_done_q;
  bit         m_err_q;
  bit         m_ovr;
  logic [7:0] m_q[$];

  always #5 clk = ~clk;

  uart_rx_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .HOLDOFF(HOLDOFF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_en    (cfg_en),
    .cfg_div   (cfg_div),
    .rx_tick   (rx_tick),
    .rx_en     (rx_en),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_err    (rx_err),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .level     (level),
    .overrun   (overrun),
    .err_count (err_count),
    .stat_clr  (stat_clr),
    .active    (active)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs the DUT sees at the edge.
  task automatic model_step();
    bit tick;
    bit d_rise;
    bit e_rise;
    bit popv;
    bit pushv;
    bit errev;
    bit ovf;
    if (!rst_n) begin
      m_mode = M_IDLE; m_cnt = 0; m_hold = 0; m_errs = 0;
      m_done_q = 1'b0; m_err_q = 1'b0; m_ovr = 1'b0;
      m_q.delete();
    end else begin
      tick   = (m_mode != M_IDLE) && (m_cnt + 1 >= int'(cfg_div));
      d_rise = rx_done && !m_done_q;
      e_rise = rx_err && !m_err_q;
      popv   = rd_en && (m_q.size() > 0);
      pushv  = 1'b0; errev = 1'b0; ovf = 1'b0;
      m_cnt  = (m_mode == M_IDLE || tick) ? 0 : m_cnt + 1;
      if (!cfg_en) m_mode = M_IDLE;
      else if (m_mode == M_IDLE) m_mode = M_ARM;
      else if (m_mode == M_ARM) begin
        if (tick) m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
        if (e_rise) begin
          errev = 1'b1; m_hold = HOLDOFF; m_mode = M_RECOVER;
        end else if (d_rise) pushv = 1'b1;
      end else begin
        if (tick) begin
          m_hold--;
          if (m_hold <= 0) m_mode = M_RUN;
        end
      end
      if (popv) void'(m_q.pop_front());
      if (pushv) begin
        if (m_q.size() < FIFO_DEPTH) m_q.push_back(rx_data);
        else ovf = 1'b1;
      end
      if (ovf) m_ovr = 1'b1;
      else if (stat_clr) m_ovr = 1'b0;
      if (errev) m_errs = stat_clr ? 1 : ((m_errs < 255) ? m_errs + 1 : 255);
      else if (stat_clr) m_errs = 0;
      m_done_q = rx_done;
      m_err_q  = rx_err;
    end
  endtask

  task automatic check_outputs();
    bit exp_tick;
    exp_tick = (m_mode != M_IDLE) && (m_cnt + 1 >= int'(cfg_div));
    check("rx_tick",   32'(rx_tick),   32'(exp_tick));
    check("rx_en",     32'(rx_en),     32'(m_mode == M_RUN));
    check("active",    32'(active),    32'(m_mode == M_RUN));
    check("rd_valid",  32'(rd_valid),  32'(m_q.size() > 0));
    check("rd_data",   32'(rd_data),   (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    check("level",     32'(level),     32'(m_q.size()));
    check("overrun",   32'(overrun),   32'(m_ovr));
    check("err_count", 32'(err_count), 32'(m_errs));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_data = b; rx_done = 1'b1; step();
    rx_done = 1'b0; step();
  endtask

  task automatic wait_run(input string tag, input int limit);
    for (int i = 0; i < limit && m_mode != M_RUN; i++) step();
    check(tag, 32'(active), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; cfg_en = 1'b0; cfg_div = 16'd4; rx_data = 8'd0;
    rx_done = 1'b0; rx_err = 1'b0; rd_en = 1'b0; stat_clr = 1'b0;
    m_mode = M_IDLE; m_cnt = 0; m_hold = 0; m_errs = 0;
    m_done_q = 1'b0; m_err_q = 1'b0; m_ovr = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) step();
    check("reset_level", 32'(level), 32'd0);

    // tick every 4th clock, enable rises after the first tick
    rst_n = 1'b1; cfg_en = 1'b1;
    for (int i = 0; i < 12; i++) step();
    wait_run("arm_to_run", 20);

    // two bytes, then one pop
    push_byte(8'h55);
    push_byte(8'hAA);
    check("two_level", 32'(level), 32'd2);
    check("two_head", 32'(rd_data), 32'h55);
    rd_en = 1'b1; step(); rd_en = 1'b0; step();
    check("pop_head", 32'(rd_data), 32'hAA);
    check("pop_level", 32'(level), 32'd1);
    rd_en = 1'b1; step(); rd_en = 1'b0; step();

    // fill past capacity
    for (int i = 0; i < 5; i++) push_byte(8'(8'h10 + i));
    check("full_level", 32'(level), 32'd4);
    check("full_ovr", 32'(overrun), 32'd1);
    check("full_head", 32'(rd_data), 32'h10);
    stat_clr = 1'b1; step(); stat_clr = 1'b0; step();
    check("clr_ovr", 32'(overrun), 32'd0);
    // push on full with same-cycle pop is not an overrun
    rx_data = 8'h15; rx_done = 1'b1; rd_en = 1'b1; step();
    rx_done = 1'b0; rd_en = 1'b0; step();
    check("pushpop_ovr", 32'(overrun), 32'd0);
    check("pushpop_level", 32'(level), 32'd4);
    check("pushpop_head", 32'(rd_data), 32'h11);
    // overrun beats a same-cycle clear
    rx_data = 8'h16; rx_done = 1'b1; stat_clr = 1'b1; step();
    rx_done = 1'b0; stat_clr = 1'b0; step();
    check("clr_vs_ovr", 32'(overrun), 32'd1);

    // framing error and hold-off
    rx_err = 1'b1; step(); rx_err = 1'b0; step();
    check("err_one", 32'(err_count), 32'd1);
    check("err_recover_en", 32'(rx_en), 32'd0);
    wait_run("recover_to_run", 16 * 4 + 8);

    // saturate the error counter
    cfg_div = 16'd1;
    for (int e = 0; e < 300; e++) begin
      rx_err = 1'b1; step(); rx_err = 1'b0; step();
      wait_run("sat_run", 40);
    end
    check("err_sat", 32'(err_count), 32'd255);
    stat_clr = 1'b1; step(); stat_clr = 1'b0; step();
    check("clr_err", 32'(err_count), 32'd0);
    check("clr_ovr2", 32'(overrun), 32'd0);

    // disable mid-byte keeps the FIFO
    rx_done = 1'b1; rx_data = 8'h77; cfg_en = 1'b0; step();
    check("dis_active", 32'(active), 32'd0);
    step(); step();
    check("dis_tick", 32'(rx_tick), 32'd0);
    check("dis_level", 32'(level), 32'd4);
    rx_done = 1'b0;
    rd_en = 1'b1; step(); rd_en = 1'b0; step();
    check("dis_drain", 32'(level), 32'd3);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check("rst_level", 32'(level), 32'd0);

    // randomized traffic
    cfg_en = 1'b1; cfg_div = 16'd2;
    for (int c = 0; c < 4000; c++) begin
      rst_n    = ($urandom_range(0, 999) != 0);
      if ($urandom_range(0, 299) == 0) cfg_en = ~cfg_en;
      else if (!cfg_en && $urandom_range(0, 7) == 0) cfg_en = 1'b1;
      if ($urandom_range(0, 199) == 0) cfg_div = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) rx_done = ~rx_done;
      if ($urandom_range(0, 59) == 0) rx_err = ~rx_err;
      rx_data  = 8'($urandom);
      rd_en    = ($urandom_range(0, 2) == 0);
      stat_clr = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, receive FIFO entries (power of two, >=2).
REQ-002 Parameter: HOLDOFF, 16, receiver-disabled ticks in RECOVER after a framing error (>=1).
REQ-003 Port: clk  in  1  system clock; all logic on rising edge.
REQ-004 Port: rst_n  in  1  synchronous, active-low reset.
REQ-005 Port: cfg_en  in  1  controller enable.
REQ-006 Port: cfg_div  in  16  clk cycles per oversample tick.
REQ-007 Port: rx_tick  out  1  one-clk tick pulse to the receiver.
REQ-008 Port: rx_en  out  1  receiver enable.
REQ-009 Port: rx_data  in  8  receiver byte.
REQ-010 Port: rx_done  in  1  receiver byte-complete level.
REQ-011 Port: rx_err  in  1  receiver framing-error level.
REQ-012 Port: rd_en  in  1  host pop request.
REQ-013 Port: rd_data  out  8  FIFO head (show-ahead); 0 when empty.
REQ-014 Port: rd_valid  out  1  FIFO not empty.
REQ-015 Port: level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-016 Port: overrun  out  1  sticky: byte dropped on full FIFO.
REQ-017 Port: err_count  out  8  saturating framing-error count.
REQ-018 Port: stat_clr  in  1  clears overrun and err_count.
REQ-019 Port: active  out  1  high only in state RUN.

Function
REQ-020 Tick generator runs in ARM/RUN/RECOVER: 16-bit cnt; when cnt+1 >= cfg_div (17-bit compare) rx_tick=1 for that cycle and cnt<=0, else cnt<=cnt+1; cfg_div 0 or 1 -> tick every cycle.
REQ-021 In IDLE cnt is held at 0 and rx_tick=0.
REQ-022 FSM states IDLE, ARM, RUN, RECOVER; cfg_en=0 in any state -> IDLE next cycle (overrides all other transitions).
REQ-023 IDLE: rx_en=0; cfg_en=1 -> ARM.
REQ-024 ARM: rx_en=0; on cycle with rx_tick=1 -> RUN (receiver sees at least one tick with en low).
REQ-025 RUN: rx_en=1; rising edge of rx_done (registered previous value) pushes rx_data into FIFO.
REQ-026 RUN: rising edge of rx_err -> err_count+1 (saturate at 255), ticks-remaining counter loaded HOLDOFF, -> RECOVER.
REQ-027 RUN: rx_done and rx_err rising edges same cycle -> error handling only, no push.
REQ-028 RECOVER: rx_en=0; decrement counter on each rx_tick; when it reaches 0 -> ARM... no: -> RUN directly; edges on rx_done/rx_err ignored.
REQ-029 Edge-detect registers update every cycle in all states; edges outside RUN are discarded.
REQ-030 Push when full: byte dropped, overrun<=1.
REQ-031 Pop: rd_en=1 and rd_valid=1 advances head; rd_en on empty ignored, no error.
REQ-032 Simultaneous push and pop: both occur, level unchanged; when full this is not an overrun.
REQ-033 Pointers wrap modulo FIFO_DEPTH; level ranges 0..FIFO_DEPTH.
REQ-034 stat_clr clears overrun and err_count; a same-cycle overrun or error event wins (overrun=1, err_count=1).
REQ-035 Entering IDLE retains FIFO contents, overrun, err_count; host may drain while disabled.

Reset
REQ-036 rst_n=0 at clk edge: state IDLE, cnt 0, FIFO empty (pointers 0), edge registers 0, hold-off counter 0.
REQ-037 Reset outputs: rx_tick 0, rx_en 0, rd_data 0, rd_valid 0, level 0, overrun 0, err_count 0, active 0.
REQ-038 Reset mid-operation (any state, full FIFO) behaves identically to power-on reset.

Verification
REQ-039 cfg_div=4, cfg_en=1 -> rx_tick every 4th clk; rx_en rises the cycle after first tick; active=1.
REQ-040 RUN, rx_done pulses with 0x55, 0xAA -> level=2, rd_data=0x55; rd_en one cycle -> rd_data=0xAA, level=1.
REQ-041 FIFO_DEPTH=4, five bytes without pop -> level=4, overrun=1, head 1st byte; 5th push with same-cycle pop -> no overrun.
REQ-042 rx_err rising in RUN, HOLDOFF=16 -> err_count=1, rx_en=0 for 16 ticks, then RUN; 300 errors -> err_count=255.
REQ-043 cfg_en dropped mid-byte -> IDLE next cycle, rx_en=0, rx_tick stops, FIFO retained; rst_n=0 -> all outputs 0.
REQ-044 stat_clr with concurrent overrun push -> overrun stays 1; stat_clr alone -> overrun 0, err_count 0.
